// File: rtl/pc_ctrl_if.sv
// Bundle between pc_ctrl and the ID/hazard/CP0 side of the pipeline.
// The master drives ID-stage decode, hazard and exception inputs; the slave (pc_ctrl) returns fetch state.
interface pc_ctrl_if;
  // Flow control: there is no valid/ready pair. stall=1 holds pc_if and bd_if,
  // unless exc_req or eret_m redirects. taken is only consumed on a non-stalled edge.
  logic        stall;
  logic [3:0]  br_type;
  logic        equal;
  logic        greater;
  logic        less;
  logic [31:0] pc_id;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic        exc_req;
  logic        eret_m;
  logic [31:0] epc;
  logic [31:0] pc_if;
  logic        taken;
  logic [31:0] link_pc;
  logic        bd_if;
  logic        adel_if;

  modport master (
    output stall, br_type, equal, greater, less, pc_id, imm16, instr_index,
           rs_val, exc_req, eret_m, epc,
    input  pc_if, taken, link_pc, bd_if, adel_if
  );

  modport slave (
    input  stall, br_type, equal, greater, less, pc_id, imm16, instr_index,
           rs_val, exc_req, eret_m, epc,
    output pc_if, taken, link_pc, bd_if, adel_if
  );
endinterface

// File: rtl/pc_ctrl.sv
// IF-stage PC controller: resolves ID branches with one delay slot, plus exception entry and eret.
// Optional macro PC_ADEL_CHECK_EN enables the fetch address-error check on adel_if.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input logic        clk,
  input logic        reset,
  pc_ctrl_if.slave   bus
);

  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] pc_id_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] target;
  logic        cond;
  logic        is_branch;
  logic [31:0] pc_next;
  logic        bd_next;

  assign pc_id_plus4 = bus.pc_id + 32'd4;
  assign branch_tgt  = pc_id_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign jump_tgt    = {pc_id_plus4[31:28], bus.instr_index, 2'b00};
  assign is_branch   = (bus.br_type >= 4'd1) && (bus.br_type <= 4'd10);

  always_comb begin
    cond   = 1'b0;
    target = branch_tgt;
    case (bus.br_type)
      4'd1:        cond = bus.equal;
      4'd2:        cond = !bus.equal;
      4'd3:        cond = bus.greater;
      4'd4:        cond = !bus.greater;
      4'd5:        cond = bus.less;
      4'd6:        cond = !bus.less;
      4'd7, 4'd8: begin
        cond   = 1'b1;
        target = jump_tgt;
      end
      4'd9, 4'd10: begin
        cond   = 1'b1;
        target = bus.rs_val;
      end
      default:     cond = 1'b0;
    endcase
  end

  // Exception and eret redirect even while the hazard unit stalls.
  always_comb begin
    pc_next = pc_q + 32'd4;
    bd_next = is_branch;
    if (bus.exc_req) begin
      pc_next = EXC_PC;
      bd_next = 1'b0;
    end else if (bus.eret_m) begin
      pc_next = bus.epc;
      bd_next = 1'b0;
    end else if (bus.stall) begin
      pc_next = pc_q;
      bd_next = bd_q;
    end else if (cond) begin
      pc_next = target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      bd_q <= 1'b0;
    end else begin
      pc_q <= pc_next;
      bd_q <= bd_next;
    end
  end

  assign bus.pc_if   = pc_q;
  assign bus.bd_if   = bd_q;
  assign bus.taken   = cond;
  assign bus.link_pc = bus.pc_id + 32'd8;

`ifdef PC_ADEL_CHECK_EN
  assign bus.adel_if = (pc_q[1:0] != 2'b00) || (pc_q < 32'h0000_3000) ||
                       (pc_q > 32'h0000_6FFC);
`else
  assign bus.adel_if = 1'b0;
`endif

endmodule
